// File: rtl/conv_relu_maxpool2x2.sv
// Streaming 2x2 / stride-2 max-pool with a half-line buffer and regenerated frame/line markers.
// Define CONV_POOL_RELU_EN to clamp negative pooled results to zero (ReLU after pool).
module conv_relu_maxpool2x2 #(
  parameter int DATA_W = 16,
  parameter int LINE_W = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     valid_in,
  input  logic                     frame_start_in,
  input  logic                     line_start_in,
  input  logic                     frame_end_in,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     out_valid,
  output logic                     frame_start_out,
  output logic                     line_start_out,
  output logic                     frame_end_out,
  output logic                     line_ovf
);

  localparam int CW   = $clog2(LINE_W + 1);
  localparam int HALF = LINE_W / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_W);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            col, pc;
  logic [AW-1:0]            idx;
  logic signed [DATA_W-1:0] hold, buf_rd, top_max, m, pooled;
  logic signed [DATA_W-1:0] linebuf [HALF];
  logic                     first_out, take, in_range, odd_row, emit, wr;

  always_ff @(posedge clk) begin : state_reg
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin : fsm_next
    // NOTE: defaults are assigned first so no path through this block can infer a latch.
    state_nxt = state;
    if (take) begin
      if (frame_end_in)        state_nxt = IDLE;
      else if (frame_start_in) state_nxt = EVEN_ROW;
      else if (line_start_in)  state_nxt = (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
    end
  end

  always_comb begin : window_logic
    take     = valid_in && (frame_start_in || (state != IDLE));
    pc       = (frame_start_in || line_start_in) ? '0 : col;
    in_range = pc < LAST_COL;
    // Row parity of the pixel being processed, accounting for a marker arriving with it.
    if (frame_start_in)     odd_row = 1'b0;
    else if (line_start_in) odd_row = (state == EVEN_ROW);
    else                    odd_row = (state == ODD_ROW);
    emit    = take && in_range && odd_row && pc[0];
    wr      = take && in_range && !odd_row && pc[0];
    idx     = AW'(pc >> 1);
    buf_rd  = linebuf[idx];
    top_max = (hold > data_in) ? hold : data_in;
    m       = (buf_rd > top_max) ? buf_rd : top_max;
`ifdef CONV_POOL_RELU_EN
    pooled  = m[DATA_W-1] ? '0 : m;
`else
    pooled  = m;
`endif
  end

  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      col             <= '0;
      hold            <= '0;
      first_out       <= 1'b0;
      line_ovf        <= 1'b0;
      data_out        <= '0;
      out_valid       <= 1'b0;
      frame_start_out <= 1'b0;
      line_start_out  <= 1'b0;
      frame_end_out   <= 1'b0;
    end else begin
      out_valid       <= emit;
      frame_start_out <= emit && first_out;
      line_start_out  <= emit && (pc == COL_ONE);
      frame_end_out   <= take && frame_end_in;
      if (emit) data_out <= pooled;
      if (take) begin
        // Column saturates at LINE_W; pixels beyond it are dropped and flagged.
        col <= in_range ? pc + COL_ONE : pc;
        if (in_range && !pc[0]) hold <= data_in;
        if (frame_start_in) begin
          first_out <= 1'b1;
          line_ovf  <= 1'b0;
        end else begin
          if (emit)      first_out <= 1'b0;
          if (!in_range) line_ovf  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin : line_buffer
    // NOTE: the line buffer has no reset; each entry is written on the even row before the odd row reads it.
    if (wr) linebuf[idx] <= top_max;
  end

endmodule

// File: tb/tb_conv_relu_maxpool2x2.sv
// Self-checking bench for conv_relu_maxpool2x2: randomized frames against a window-level pooling model.
// Expected values follow CONV_POOL_RELU_EN the same way the design does.
module tb_conv_relu_maxpool2x2;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  logic signed [DW-1:0] data_in;
  logic valid_in, fs_in, ls_in, fe_in;

  logic signed [DW-1:0] d4, d5, o_d;
  logic v4, v5, fso4, fso5, lso4, lso5, feo4, feo5, ovf4, ovf5;
  logic o_v, o_fs, o_ls, o_fe, o_ovf;
  int   sel_w = 4;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct packed {
    logic          v;
    logic          fs;
    logic          ls;
    logic          fe;
    logic [31:0]   cyc;
    logic [DW-1:0] d;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  logic signed [DW-1:0] pix [0:7][0:7];
  int pcyc [0:7][0:7];

  conv_relu_maxpool2x2 #(.DATA_W(DW), .LINE_W(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .frame_start_in(fs_in), .line_start_in(ls_in), .frame_end_in(fe_in),
    .data_out(d4), .out_valid(v4), .frame_start_out(fso4), .line_start_out(lso4),
    .frame_end_out(feo4), .line_ovf(ovf4)
  );

  conv_relu_maxpool2x2 #(.DATA_W(DW), .LINE_W(5)) dut5 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .frame_start_in(fs_in), .line_start_in(ls_in), .frame_end_in(fe_in),
    .data_out(d5), .out_valid(v5), .frame_start_out(fso5), .line_start_out(lso5),
    .frame_end_out(feo5), .line_ovf(ovf5)
  );

  always_comb begin
    if (sel_w == 5) {o_d, o_v, o_fs, o_ls, o_fe, o_ovf} = {d5, v5, fso5, lso5, feo5, ovf5};
    else            {o_d, o_v, o_fs, o_ls, o_fe, o_ovf} = {d4, v4, fso4, lso4, feo4, ovf4};
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are sampled on the falling edge, tagged with the number of rising edges so far.
  always @(negedge clk) begin
    if (o_v === 1'b1 || o_fe === 1'b1)
      obs_q.push_back(ev_t'({o_v, o_fs, o_ls, o_fe, 32'(cyc), (o_v ? o_d : {DW{1'b0}})}));
  end

  function automatic string fmt(ev_t e);
    return $sformatf("v=%0b fs=%0b ls=%0b fe=%0b cyc=%0d d=%0d",
                     e.v, e.fs, e.ls, e.fe, e.cyc, $signed(e.d));
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = DW'($urandom);
    fs_in    = 1'($urandom);
    ls_in    = 1'($urandom);
    fe_in    = 1'($urandom);
  endtask

  task automatic send_pix(input logic signed [DW-1:0] v, input bit fs, input bit ls, input bit fe);
    @(negedge clk);
    data_in = v; valid_in = 1'b1; fs_in = fs; ls_in = ls; fe_in = fe;
  endtask

  task automatic start_test(input int w);
    sel_w = w;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic fill_ramp(input int nr, input int nc, input int off, input bit neg);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        pix[r][c] = neg ? DW'(-(r * nc + c + off)) : DW'(r * nc + c + off);
  endtask

  // Drives one frame of nr rows x nc pixels, checks the sticky overflow flag as it goes,
  // and appends the expected pooled stream computed from whole 2x2 windows.
  task automatic run_frame(input int nr, input int nc, input int lw, input bit bubbles);
    bit ovf_exp = 1'b0;
    bit first = 1'b1;
    int eff, lc;
    logic signed [DW-1:0] m;
    ev_t t;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        if (bubbles && $urandom_range(3) == 0) idle_cycle();
        @(negedge clk);
        if (r != 0 || c != 0) begin
          n_cmp++;
          if (o_ovf !== ovf_exp) begin
            n_err++;
            $display("FAIL line_ovf before pixel r%0d c%0d: got %b, want %b", r, c, o_ovf, ovf_exp);
          end
        end
        data_in = pix[r][c]; valid_in = 1'b1;
        fs_in = (r == 0 && c == 0); ls_in = (c == 0); fe_in = (r == nr - 1 && c == nc - 1);
        pcyc[r][c] = cyc;
        if (c >= lw) ovf_exp = 1'b1;
      end
    end
    eff = (nc < lw) ? nc : lw;
    for (int p = 0; 2 * p + 1 < nr; p++) begin
      for (int j = 0; j < eff / 2; j++) begin
        m = pix[2*p][2*j];
        if (pix[2*p][2*j+1]   > m) m = pix[2*p][2*j+1];
        if (pix[2*p+1][2*j]   > m) m = pix[2*p+1][2*j];
        if (pix[2*p+1][2*j+1] > m) m = pix[2*p+1][2*j+1];
`ifdef CONV_POOL_RELU_EN
        if (m < 0) m = '0;
`endif
        exp_q.push_back(ev_t'({1'b1, first, (j == 0), 1'b0, 32'(pcyc[2*p+1][2*j+1] + 1), m}));
        first = 1'b0;
      end
    end
    lc = pcyc[nr-1][nc-1] + 1;
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc == 32'(lc)) begin
      t = exp_q.pop_back();
      t.fe = 1'b1;
      exp_q.push_back(t);
    end else begin
      exp_q.push_back(ev_t'({1'b0, 1'b0, 1'b0, 1'b1, 32'(lc), {DW{1'b0}}}));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; data_in = '0; fs_in = 1'b0; ls_in = 1'b0; fe_in = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({d4, v4, fso4, lso4, feo4, ovf4} !== '0) begin
      n_err++;
      $display("FAIL reset dut4: got d=%0d v=%b fs=%b ls=%b fe=%b ovf=%b, want all 0", d4, v4, fso4, lso4, feo4, ovf4);
    end
    n_cmp++;
    if ({d5, v5, fso5, lso5, feo5, ovf5} !== '0) begin
      n_err++;
      $display("FAIL reset dut5: got d=%0d v=%b fs=%b ls=%b fe=%b ovf=%b, want all 0", d5, v5, fso5, lso5, feo5, ovf5);
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp4();
    start_test(4);
    fill_ramp(4, 4, 0, 1'b0);
    run_frame(4, 4, 4, 1'b0);
    repeat (3) idle_cycle();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL ramp4 count: got %0d events, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL ramp4 event %0d: got %s, want %s", i, (i < obs_q.size()) ? fmt(obs_q[i]) : "none", fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_negative();
    start_test(4);
    fill_ramp(4, 4, 0, 1'b1);
    run_frame(4, 4, 4, 1'b0);
    repeat (3) idle_cycle();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL negative count: got %0d events, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL negative event %0d: got %s, want %s", i, (i < obs_q.size()) ? fmt(obs_q[i]) : "none", fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_ramp5();
    start_test(5);
    fill_ramp(5, 5, 0, 1'b0);
    run_frame(5, 5, 5, 1'b0);
    repeat (3) idle_cycle();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL ramp5 count: got %0d events, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL ramp5 event %0d: got %s, want %s", i, (i < obs_q.size()) ? fmt(obs_q[i]) : "none", fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    start_test(4);
    fill_ramp(4, 4, 0, 1'b0);
    run_frame(4, 4, 4, 1'b0);
    fill_ramp(4, 4, 100, 1'b0);
    run_frame(4, 4, 4, 1'b0);
    repeat (3) idle_cycle();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL back_to_back count: got %0d events, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL back_to_back event %0d: got %s, want %s", i, (i < obs_q.size()) ? fmt(obs_q[i]) : "none", fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    start_test(4);
    fill_ramp(4, 4, 0, 1'b0);
    for (int k = 0; k < 5; k++) send_pix(pix[k/4][k%4], (k == 0), (k % 4 == 0), 1'b0);
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_d, o_v, o_fs, o_ls, o_fe, o_ovf} !== '0) begin
      n_err++;
      $display("FAIL mid_reset outputs: got d=%0d v=%b fs=%b ls=%b fe=%b ovf=%b, want all 0", o_d, o_v, o_fs, o_ls, o_fe, o_ovf);
    end
    rst = 1'b0;
    // Rest of the aborted row arrives without a new frame start and must be ignored.
    for (int c = 1; c < 4; c++) send_pix(pix[1][c], 1'b0, 1'b0, 1'b0);
    idle_cycle();
    run_frame(4, 4, 4, 1'b0);
    repeat (3) idle_cycle();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL mid_reset count: got %0d events, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL mid_reset event %0d: got %s, want %s", i, (i < obs_q.size()) ? fmt(obs_q[i]) : "none", fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_overflow();
    start_test(4);
    fill_ramp(4, 6, 0, 1'b0);
    run_frame(4, 6, 4, 1'b0);
    repeat (3) idle_cycle();
    n_cmp++;
    if (o_ovf !== 1'b1) begin
      n_err++; $display("FAIL overflow sticky: got %b, want 1", o_ovf);
    end
    fill_ramp(4, 4, 0, 1'b0);
    run_frame(4, 4, 4, 1'b0);
    repeat (3) idle_cycle();
    n_cmp++;
    if (o_ovf !== 1'b0) begin
      n_err++; $display("FAIL overflow cleared: got %b, want 0", o_ovf);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL overflow count: got %0d events, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL overflow event %0d: got %s, want %s", i, (i < obs_q.size()) ? fmt(obs_q[i]) : "none", fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_random();
    int w, nf, nr, nc;
    for (int b = 0; b < 12; b++) begin
      w  = ($urandom_range(1) == 0) ? 4 : 5;
      nf = $urandom_range(3, 1);
      start_test(w);
      // Stray pixels while idle must produce nothing.
      repeat (3) send_pix(DW'($urandom), 1'b0, 1'($urandom), 1'b0);
      idle_cycle();
      for (int f = 0; f < nf; f++) begin
        nr = $urandom_range(6, 2);
        nc = $urandom_range(7, 2);
        for (int r = 0; r < nr; r++)
          for (int c = 0; c < nc; c++) pix[r][c] = DW'($urandom);
        run_frame(nr, nc, w, 1'b1);
        if ($urandom_range(1) == 1) idle_cycle();
      end
      repeat (3) idle_cycle();
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL random batch %0d count: got %0d events, want %0d", b, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        n_cmp++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL random batch %0d event %0d: got %s, want %s", b, i, (i < obs_q.size()) ? fmt(obs_q[i]) : "none", fmt(exp_q[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp4();
    test_negative();
    test_ramp5();
    test_back_to_back();
    test_reset_mid_frame();
    test_overflow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
